alu_exec_unit: RTL and testbench

//  Execute-stage ALU consuming the 4-bit ALU control code from the ALU control decoder plus two operands.

---
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_exec_unit.sv | 126 ++++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle for the execute-stage ALU: request side (valid/ready, op code, operands)
// and response side (valid/ready, result, zero), plus the busy indicator.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/logic/compare, iterative 1-bit-per-cycle shifter,
// valid/ready on both sides with a registered result and zero flag.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic           clk,
    input logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpSll  = 4'b0010;
    localparam logic [3:0] OpSlt  = 4'b0011;
    localparam logic [3:0] OpSltu = 4'b0100;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpOr   = 4'b1000;
    localparam logic [3:0] OpAnd  = 4'b1001;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [XLEN-1:0]    acc_q;
    logic [XLEN-1:0]    result_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [3:0]         op_q;
    logic               zero_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [XLEN-1:0]    alu_res;
    logic [XLEN-1:0]    shift_next;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               slt_bit;
    logic               sltu_bit;

    assign shamt    = bus.op_b[SHAMT_W-1:0];
    assign is_shift = (bus.alu_ctrl == OpSll) || (bus.alu_ctrl == OpSrl) ||
                      (bus.alu_ctrl == OpSra);
    assign slt_bit  = $signed(bus.op_a) < $signed(bus.op_b);
    assign sltu_bit = bus.op_a < bus.op_b;

    // Shift codes fall into the default here; they never take this path.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            OpAdd:   alu_res = bus.op_a + bus.op_b;
            OpSub:   alu_res = bus.op_a - bus.op_b;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
            OpXor:   alu_res = bus.op_a ^ bus.op_b;
            OpOr:    alu_res = bus.op_a | bus.op_b;
            OpAnd:   alu_res = bus.op_a & bus.op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shift_next = acc_q;
        case (op_q)
            OpSll:   shift_next = acc_q << 1;
            OpSrl:   shift_next = acc_q >> 1;
            OpSra:   shift_next = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: shift_next = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        busy_q <= 1'b1;
                        if (is_shift && (shamt != '0)) begin
                            acc_q   <= bus.op_a;
                            cnt_q   <= shamt;
                            op_q    <= bus.alu_ctrl;
                            state_q <= StShift;
                        end else begin
                            result_q    <= is_shift ? bus.op_a : alu_res;
                            zero_q      <= is_shift ? (bus.op_a == '0) : (alu_res == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StShift: begin
                    acc_q <= shift_next;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q    <= shift_next;
                        zero_q      <= (shift_next == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed and random ops against an arithmetic reference model.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic        z;
        int unsigned vis;
        logic [3:0]  c;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        int n;
        n = int'(b % 32);
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << n;
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a >> n;
            4'd7: r = $signed(a) >>> n;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic int unsigned op_latency(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'd2 || c == 4'd6 || c == 4'd7) return b % 32;
        return 0;
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        int waited;
        bit accepted;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        waited   = 0;
        accepted = 0;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                m = model(c, a, b);
                sbq.push_back('{r: m[31:0], z: m[32], vis: cyc + 1 + op_latency(c, b), c: c});
                accepted = 1;
            end else begin
                waited++;
            end
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept, required accept within 100 cycles");
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sbq.size() != 0 || bus.out_valid) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on out_valid and checks latency, hold-while-stalled and release.
    initial begin
        bit seen = 0, stall = 0, post_hs = 0;
        logic [31:0] held_r;
        logic held_z;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0; stall = 0; post_hs = 0;
            end else begin
                if (post_hs) begin
                    chk("in_ready_after_handshake", bus.in_ready, 1);
                    chk("out_valid_after_handshake", bus.out_valid, 0);
                    post_hs = 0;
                end
                if (stall) begin
                    chk("stall_out_valid", bus.out_valid, 1);
                    chk("stall_result", bus.result, held_r);
                    chk("stall_zero", bus.zero, held_z);
                end
                if (bus.out_valid) begin
                    chk("in_ready_while_done", bus.in_ready, 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 result=%h, required none",
                                 bus.result);
                    end else if (!seen) begin
                        seen = 1;
                        chk($sformatf("latency_op%0d", sbq[0].c), cyc, sbq[0].vis);
                        chk($sformatf("result_op%0d", sbq[0].c), bus.result, sbq[0].r);
                        chk($sformatf("zero_op%0d", sbq[0].c), bus.zero, sbq[0].z);
                    end
                    if (bus.out_ready) begin
                        if (sbq.size() != 0) void'(sbq.pop_front());
                        seen = 0; stall = 0; post_hs = 1;
                    end else begin
                        stall = 1; held_r = bus.result; held_z = bus.zero;
                    end
                end else begin
                    stall = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_result", bus.result, 0);
        chk("reset_zero", bus.zero, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("idle_in_ready", bus.in_ready, 1);

        // in_valid stays high across these back-to-back ops.
        issue(4'd0, 32'd5, 32'd7);
        issue(4'd1, 32'h1234, 32'h1234);
        issue(4'd3, 32'hFFFF_FFFF, 32'd1);
        issue(4'd4, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 32'h8000_0000, 32'd4);
        issue(4'd6, 32'h8000_0000, 32'd4);
        issue(4'd2, 32'd1, 32'd31);
        issue(4'd2, 32'hDEAD_BEEF, 32'h20);
        issue(4'd15, 32'h1111_2222, 32'h3333_4444);
        issue(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'd8, 32'h0000_00F0, 32'h0000_0F00);
        issue(4'd9, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Consumer stalls three cycles in DONE, then accepts.
        ready_mode = 2;
        issue(4'd0, 32'd100, 32'd23);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        ready_mode = 0;
        drain();

        // Reset during an SLL shift drops the op.
        issue(4'd2, 32'h0000_0003, 32'd10);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("in_ready_mid_reset", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_result", bus.result, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        repeat (15) @(negedge clk);
        issue(4'd0, 32'd40, 32'd2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) a = b;
            issue(c, a, b);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
